// File: rtl/ysyx_25030093_ifu_ctrl_if.sv
// Instruction-bus read channel (AR/R) plus the IFU->IDU instruction hand-off.
// Every channel here is valid/ready: a transfer happens on the rising edge where both are
// high; once valid is raised, the source holds it and its payload stable until that edge.
interface ysyx_25030093_ifu_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic [1:0]        fetch_err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output araddr, arvalid, rready, inst, inst_pc, fetch_err, out_valid,
    input  arready, rdata, rresp, rvalid, out_ready
  );

  modport slave (
    input  araddr, arvalid, rready, inst, inst_pc, fetch_err, out_valid,
    output arready, rdata, rresp, rvalid, out_ready
  );
endinterface

// File: rtl/ysyx_25030093_ifu_ctrl.sv
// Instruction-fetch sequencer: one bus read per instruction, hand-off to the IDU, then wait for WBU.
// Define IFU_PERF_EN to build the fetch/stall performance counters; otherwise both ports read 0.
module ysyx_25030093_ifu_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        pc,
  ysyx_25030093_ifu_ctrl_if.master bus,
  input  logic                     wb_valid,
  output logic                     busy,
  output logic [31:0]              perf_fetch_cnt,
  output logic [31:0]              perf_stall_cnt,
  output logic [1:0]               state_dbg
);
  localparam logic [1:0] S_REQ      = 2'd0;
  localparam logic [1:0] S_WAIT_RSP = 2'd1;
  localparam logic [1:0] S_HOLD     = 2'd2;
  localparam logic [1:0] S_WAIT_WB  = 2'd3;

  localparam logic [1:0] E_OK       = 2'b00;
  localparam logic [1:0] E_MISALIGN = 2'b01;
  localparam logic [1:0] E_BUS      = 2'b10;
  localparam logic [1:0] E_TIMEOUT  = 2'b11;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  logic [1:0]        state, state_nxt;
  logic              addr_held;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] inst_pc_q;
  logic [DATA_W-1:0] inst_q;
  logic [1:0]        err_q;
  logic [15:0]       to_cnt, to_cnt_inc;
  logic              misaligned, ar_fire, timeout;

  // The PC register updates on the same edge that brings us into REQ, so the first REQ
  // cycle reads pc live; later REQ cycles replay the latched copy to keep araddr stable.
  always_comb begin
    req_addr   = addr_held ? inst_pc_q : pc;
    misaligned = (state == S_REQ) && !addr_held && (pc[1:0] != 2'b00);
    ar_fire    = bus.arvalid && bus.arready;
    to_cnt_inc = to_cnt + 16'd1;
    timeout    = (state == S_WAIT_RSP) && (to_cnt_inc == TO_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_REQ: begin
        if (misaligned)   state_nxt = S_HOLD;
        else if (ar_fire) state_nxt = S_WAIT_RSP;
      end
      S_WAIT_RSP: if (bus.rvalid || timeout) state_nxt = S_HOLD;
      S_HOLD:     if (bus.out_ready)         state_nxt = S_WAIT_WB;
      S_WAIT_WB:  if (wb_valid)              state_nxt = S_REQ;
      default:                               state_nxt = S_REQ;
    endcase
  end

  // arvalid is masked while rst is high so no request leaks out during a held reset.
  always_comb begin
    bus.araddr    = req_addr;
    bus.arvalid   = (state == S_REQ) && !rst && (req_addr[1:0] == 2'b00);
    bus.rready    = (state == S_WAIT_RSP);
    bus.out_valid = (state == S_HOLD);
    bus.inst      = inst_q;
    bus.inst_pc   = inst_pc_q;
    bus.fetch_err = err_q;
    busy          = (state != S_WAIT_WB);
    state_dbg     = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_held <= 1'b0;
      inst_pc_q <= '0;
      inst_q    <= '0;
      err_q     <= E_OK;
      to_cnt    <= '0;
    end else begin
      addr_held <= (state == S_REQ) && (state_nxt == S_REQ);
      if ((state == S_REQ) && !addr_held) inst_pc_q <= pc;
      if (misaligned) begin
        inst_q <= '0;
        err_q  <= E_MISALIGN;
      end
      if (state == S_WAIT_RSP) begin
        // A response arriving on the timeout edge still counts as data.
        if (bus.rvalid) begin
          inst_q <= bus.rdata;
          err_q  <= (bus.rresp == 2'b00) ? E_OK : E_BUS;
        end else if (timeout) begin
          inst_q <= '0;
          err_q  <= E_TIMEOUT;
        end
        to_cnt <= (bus.rvalid || timeout) ? 16'd0 : to_cnt_inc;
      end
    end
  end

`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready)                fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if ((state == S_REQ) || (state == S_WAIT_RSP))     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_ysyx_25030093_ifu_ctrl.sv
// Bench for ysyx_25030093_ifu_ctrl: transaction-planned stimulus, per-cycle compare against
// the plan's expected phase, and a queue of expected {fetch_err, inst_pc, inst} records.
module tb_ysyx_25030093_ifu_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int W  = 66;

  // Phase numbering of the state_dbg port
  localparam logic [1:0] P_REQ = 2'd0, P_RSP = 2'd1, P_HOLD = 2'd2, P_WB = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] pc = '0;
  logic          wb_valid = 1'b0;
  logic          busy;
  logic [31:0]   pf, ps;
  logic [1:0]    state_dbg;

  ysyx_25030093_ifu_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ysyx_25030093_ifu_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .bus            (bus),
    .wb_valid       (wb_valid),
    .busy           (busy),
    .perf_fetch_cnt (pf),
    .perf_stall_cnt (ps),
    .state_dbg      (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  logic          chk_en = 1'b0;
  logic [1:0]    e_state = P_REQ;
  logic          e_arvalid = 1'b0, e_rready = 1'b0, e_out_valid = 1'b0, e_busy = 1'b1;
  logic [AW-1:0] e_araddr = '0;
  logic [31:0]   m_fetch = 0, m_stall = 0;

  int            cyc_since_rst = 0, first_ov_cyc = -1;
  int            ar_cnt = 0, rr_cnt = 0, last_ar = 0, last_rr = 0;
  logic [AW-1:0] last_araddr = '0;
  logic [W-1:0]  last_hs = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", state_dbg, e_state);
      chk("arvalid", bus.arvalid, e_arvalid);
      if (e_arvalid) chk("araddr", bus.araddr, e_araddr);
      chk("rready", bus.rready, e_rready);
      chk("out_valid", bus.out_valid, e_out_valid);
      chk("busy", busy, e_busy);
      if (e_out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL exp_q: out_valid expected with no record queued");
        end else begin
          chk("inst_rec", {bus.fetch_err, bus.inst_pc, bus.inst}, exp_q[0]);
        end
      end
`ifdef IFU_PERF_EN
      chk("perf_fetch", pf, m_fetch);
      chk("perf_stall", ps, m_stall);
`else
      chk("perf_fetch", pf, 32'd0);
      chk("perf_stall", ps, 32'd0);
`endif
      if (bus.arvalid) ar_cnt++;
      if (bus.arvalid && bus.arready) last_araddr = bus.araddr;
      if (bus.rready) rr_cnt++;
      if (bus.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc_since_rst;
      if (e_out_valid && bus.out_ready) begin
        last_hs = {bus.fetch_err, bus.inst_pc, bus.inst};
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        last_ar = ar_cnt;
        last_rr = rr_cnt;
        ar_cnt  = 0;
        rr_cnt  = 0;
        m_fetch++;
      end
      if (e_state == P_REQ || e_state == P_RSP) m_stall++;
      cyc_since_rst++;
    end
    if (rst) begin
      m_fetch = 0;
      m_stall = 0;
      cyc_since_rst = 0;
      first_ov_cyc = -1;
      ar_cnt = 0;
      rr_cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic [1:0] ph, input logic av, input logic [AW-1:0] aa);
    e_state     = ph;
    e_arvalid   = av;
    e_araddr    = aa;
    e_rready    = (ph == P_RSP);
    e_out_valid = (ph == P_HOLD);
    e_busy      = (ph != P_WB);
  endtask

  task automatic do_reset(input logic [AW-1:0] p);
    chk_en = 1'b0;
    rst = 1'b1;
    pc = $urandom;
    bus.arready = 1'b0;
    bus.rvalid = 1'b0;
    bus.out_ready = 1'b0;
    wb_valid = 1'b0;
    exp_q.delete();
    step();
    step();
    @(negedge clk);
    chk("rst_state", state_dbg, P_REQ);
    chk("rst_arvalid", bus.arvalid, 1'b0);
    chk("rst_rready", bus.rready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_fetch_err", bus.fetch_err, 2'b00);
    chk("rst_perf", {pf, ps}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pc = p;
    chk_en = 1'b1;
  endtask

  // One complete fetch starting in its first REQ cycle. r_dly < 0 means no response (timeout).
  task automatic fetch(input logic [AW-1:0] p, input int ar_dly, input int r_dly,
                       input logic [1:0] resp, input logic [DW-1:0] data,
                       input int out_dly, input int wb_dly);
    logic [1:0]    err;
    logic [DW-1:0] ins;
    pc = p;
    wb_valid = 1'b0;
    bus.rvalid = 1'b0;
    bus.out_ready = 1'b0;
    if (p[1:0] != 2'b00) begin
      bus.arready = 1'($urandom_range(0, 1));
      set_exp(P_REQ, 1'b0, p);
      step();
      err = 2'b01;
      ins = '0;
    end else begin
      for (int i = 0; i <= ar_dly; i++) begin
        bus.arready = (i == ar_dly);
        set_exp(P_REQ, 1'b1, p);
        step();
        pc = $urandom;
      end
      bus.arready = 1'b0;
      if (r_dly < 0) begin
        for (int k = 0; k < TO; k++) begin
          bus.rvalid = 1'b0;
          bus.rdata = $urandom;
          bus.rresp = 2'($urandom);
          set_exp(P_RSP, 1'b0, p);
          step();
        end
        err = 2'b11;
        ins = '0;
      end else begin
        for (int k = 0; k <= r_dly; k++) begin
          bus.rvalid = (k == r_dly);
          bus.rdata = (k == r_dly) ? data : DW'($urandom);
          bus.rresp = (k == r_dly) ? resp : 2'($urandom);
          set_exp(P_RSP, 1'b0, p);
          step();
        end
        err = (resp == 2'b00) ? 2'b00 : 2'b10;
        ins = data;
      end
    end
    exp_q.push_back({err, p, ins});
    bus.arready = 1'b0;
    for (int i = 0; i <= out_dly; i++) begin
      bus.out_ready = (i == out_dly);
      wb_valid = 1'($urandom_range(0, 1));
      bus.rvalid = 1'($urandom_range(0, 1));
      bus.rdata = $urandom;
      set_exp(P_HOLD, 1'b0, p);
      step();
    end
    bus.rvalid = 1'b0;
    for (int i = 0; i <= wb_dly; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      wb_valid = (i == wb_dly);
      set_exp(P_WB, 1'b0, p);
      step();
    end
    wb_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.arready = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = '0;
    bus.rresp = 2'b00;
    bus.out_ready = 1'b0;

    // Minimum-latency fetch
    do_reset(32'h8000_0000);
    fetch(32'h8000_0000, 0, 0, 2'b00, 32'h0000_0413, 0, 0);
    chk("t1_first_out_valid_cycle", first_ov_cyc, 2);
    chk("t1_araddr", last_araddr, 32'h8000_0000);
    chk("t1_record", last_hs, {2'b00, 32'h8000_0000, 32'h0000_0413});

    // Slow arready and slow IDU, new pc after the WBU pulse
    fetch(32'h8000_0004, 3, 1, 2'b00, 32'h0010_0093, 2, 1);
    chk("t2_arvalid_cycles", last_ar, 4);
    chk("t3_next_araddr", last_araddr, 32'h8000_0004);
    fetch(32'h8000_0008, 1, 2, 2'b00, 32'hdead_beef, 3, 2);
    chk("t3_record", last_hs, {2'b00, 32'h8000_0008, 32'hdead_beef});

    // Misaligned pc and bus error
    fetch(32'h8000_0002, 0, 0, 2'b00, 32'h1234_5678, 0, 0);
    chk("t4_misaligned", last_hs, {2'b01, 32'h8000_0002, 32'h0000_0000});
    chk("t4_no_arvalid", last_ar, 0);
    fetch(32'h8000_000c, 0, 1, 2'b10, 32'h5555_aaaa, 1, 0);
    chk("t4_bus_err", last_hs, {2'b10, 32'h8000_000c, 32'h5555_aaaa});

    // Timeout, then response on the timeout cycle
    fetch(32'h8000_0010, 0, -1, 2'b00, 32'h0, 0, 0);
    chk("t5_timeout_rec", last_hs, {2'b11, 32'h8000_0010, 32'h0000_0000});
    chk("t5_timeout_cycles", last_rr, 8);
    fetch(32'h8000_0014, 0, 7, 2'b00, 32'hcafe_f00d, 0, 0);
    chk("t5_late_data", last_hs, {2'b00, 32'h8000_0014, 32'hcafe_f00d});
    chk("t5_late_cycles", last_rr, 8);

    // Reset while waiting for a response
    do_reset(32'h8000_0100);
    fetch(32'h8000_0100, 0, 0, 2'b00, 32'h0000_0013, 0, 0);
    pc = 32'h8000_0200;
    bus.arready = 1'b1;
    set_exp(P_REQ, 1'b1, 32'h8000_0200);
    step();
    bus.arready = 1'b0;
    set_exp(P_RSP, 1'b0, 32'h8000_0200);
    step();
    chk_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    fetch(32'h8000_0300, 0, -1, 2'b00, 32'h0, 0, 0);
    chk("t6_after_rst_timeout", last_rr, 8);
    fetch(32'h8000_0304, 1, 2, 2'b00, 32'h0000_0293, 1, 1);
    fetch(32'h8000_0309, 0, 0, 2'b00, 32'h0, 0, 0);
`ifdef IFU_PERF_EN
    chk("t6_perf_fetch", pf, 32'd3);
    chk("t6_perf_stall", ps, 32'd15);
`else
    chk("t6_perf_fetch", pf, 32'd0);
    chk("t6_perf_stall", ps, 32'd0);
`endif

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] p;
      int rd;
      p = $urandom;
      if ($urandom_range(0, 4) != 0) p[1:0] = 2'b00;
      rd = $urandom_range(0, 9);
      if (rd > TO - 1) rd = -1;
      fetch(p, $urandom_range(0, 3), rd, 2'($urandom), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_25030093_ifu_ctrl.md
Name: ysyx_25030093_ifu_ctrl

Overview:
Instruction-fetch sequencer for the multi-cycle core. It takes the current PC from the PC register and issues one read on the AXI-lite-style instruction bus. It hands the returned instruction to the IDU over a valid/ready handshake, then waits for the WBU completion pulse before the next fetch. It also detects misaligned PCs, bus errors and response timeouts, and tags the delivered instruction with an error code.

Parameters:
ADDR_W, 32, PC and bus address width
DATA_W, 32, instruction/read-data width
TIMEOUT_CYC, 255, max cycles in WAIT_RSP before timeout fault (1..65535)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
pc  in  ADDR_W  current PC from PC register
araddr  out  ADDR_W  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  DATA_W  read data
rresp  in  2  read response, 00 = OKAY, others = error
rvalid  in  1  read data valid
rready  out  1  read data ready
inst  out  DATA_W  fetched instruction to IDU
inst_pc  out  ADDR_W  PC the instruction was fetched from
fetch_err  out  2  00 ok, 01 misaligned, 10 bus error, 11 timeout
out_valid  out  1  inst valid to IDU
out_ready  in  1  IDU accepts inst
wb_valid  in  1  one-cycle WBU completion pulse; same signal that enables the PC update
busy  out  1  high in any state except WAIT_WB
perf_fetch_cnt  out  32  completed fetches (see Optional Feature)
perf_stall_cnt  out  32  cycles spent in REQ+WAIT_RSP (see Optional Feature)

Behaviour:
- States: REQ, WAIT_RSP, HOLD, WAIT_WB. Encoding is free.
- Reset (rst=1 at posedge):
  - state -> REQ
  - arvalid=0, rready=0, out_valid=0
  - inst=0, inst_pc=0, fetch_err=00
  - timeout counter=0
  - first request is issued in the first cycle after rst deasserts.
- REQ:
  - On the first cycle in the state, latch araddr/inst_pc = pc.
  - If pc[1:0]!=0: assert no bus request; inst=0, fetch_err=01; next state HOLD.
  - Otherwise arvalid=1, held with a stable araddr until arready. On arvalid&&arready, next state is WAIT_RSP.
  - arready is allowed in the same cycle arvalid first rises.
- WAIT_RSP:
  - rready=1 for the whole state; counter increments each cycle.
  - On rvalid: inst=rdata, fetch_err = (rresp==00) ? 00 : 10; next state HOLD.
  - rvalid is accepted in the first WAIT_RSP cycle.
  - If the counter reaches TIMEOUT_CYC with no rvalid: inst=0, fetch_err=11; next state HOLD.
  - rvalid on the same edge as the timeout wins: data is taken, not a timeout.
  - Counter clears on exit.
- HOLD:
  - out_valid=1; inst, inst_pc and fetch_err held stable.
  - On out_valid&&out_ready, next state is WAIT_WB and out_valid drops the following cycle.
- WAIT_WB:
  - On wb_valid, next state is REQ. The PC register updates on the same edge, so REQ samples the new PC.
- Protocol rules:
  - wb_valid in any state other than WAIT_WB is ignored.
  - rvalid outside WAIT_RSP is not consumed (rready=0). Late responses after a timeout are a bus violation.
  - rst mid-transaction abandons the transaction immediately. The bus must be reset together with this block.
- Latency:
  - Minimum from entering REQ to out_valid high is 2 cycles (arready immediate, rvalid in the next cycle).
  - A misaligned PC gives out_valid 1 cycle after entering REQ.
- Widths: the timeout counter is 16 bits, compared by equality, with no wrap inside WAIT_RSP.

Optional Feature:
IFU_PERF_EN
- Defined:
  - perf_fetch_cnt increments on each out_valid&&out_ready.
  - perf_stall_cnt increments each cycle in REQ or WAIT_RSP.
  - Both are 32-bit, wrap at 2^32, and clear on rst.
- Undefined: no counter registers exist and both ports are tied to 0.

Test Plan:
1. Reset, then pc=0x80000000, arready=1, rvalid next cycle with rdata=0x00000413, rresp=00 -> araddr=0x80000000; out_valid exactly 2 cycles after reset release; inst=0x00000413, fetch_err=00.
2. arready delayed 3 cycles, out_ready delayed 2 cycles -> arvalid held with araddr stable for 4 cycles; inst held stable while out_valid=1 and out_ready=0.
3. After handshake, wb_valid pulse while pc changes to 0x80000004 -> next araddr=0x80000004. An extra wb_valid pulse injected during HOLD -> ignored, no extra fetch.
4. pc=0x80000002 -> arvalid never rises; out_valid=1 next cycle with inst=0, fetch_err=01. rresp=10 on an aligned fetch -> fetch_err=10.
5. TIMEOUT_CYC=8, rvalid never asserted -> fetch_err=11 after 8 WAIT_RSP cycles. Second run with rvalid on the 8th cycle -> data taken, fetch_err=00.
6. rst asserted while in WAIT_RSP -> next cycle state REQ, out_valid=0, arvalid re-asserts with the current pc. With IFU_PERF_EN defined: after 3 fetches perf_fetch_cnt=3 and perf_stall_cnt equals the counted REQ+WAIT_RSP cycles. Undefined: both read 0.
